triangle_fetcher: RTL and testbench

TRIANGLE_FETCHER -- requirements
Module: triangle_fetcher

---
 rtl/triangle_fetcher_pkg.sv | 22 ++
 rtl/triangle_fetcher_fifo2.sv | 54 +++++
 rtl/triangle_fetcher.sv | 209 ++++++++++++++++++++
 tb/tb_triangle_fetcher.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_fetcher_pkg.sv
// Shared types and constants for the triangle fetcher: FSM states, FIFO payload, FIFO depth.
package triangle_fetcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } tri_state_e;

    typedef struct packed {
        logic [127:0] v0;
        logic [127:0] v1;
        logic [127:0] v2;
        logic [31:0]  tid;
        logic         last;
    } tri_payload_t;

    localparam int FIFO_DEPTH = 2;
    localparam int PAYLOAD_W  = $bits(tri_payload_t);

endpackage

// File: rtl/triangle_fetcher_fifo2.sv
// tri_fifo2: two-entry payload FIFO with valid/ready output and a synchronous clear.
module tri_fifo2
    import triangle_fetcher_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 push_i,
    input  logic [PAYLOAD_W-1:0] push_data_i,
    input  logic                 pop_ready_i,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] data_o,
    output logic [1:0]           count_o
);

    logic [PAYLOAD_W-1:0] mem_q [FIFO_DEPTH];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic                 push_s;
    logic                 pop_s;

    assign valid_o = (count_q != 2'd0);
    assign push_s  = push_i && (count_q != 2'(FIFO_DEPTH));
    assign pop_s   = valid_o && pop_ready_i;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy; clearing also zeroes the payload seen downstream.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/triangle_fetcher.sv
// triangle_fetcher: fetches num_tri triangles from triangle memory into a 2-entry output FIFO.
// Optional WAIT watchdog with sticky timeout_err port is enabled by defining TRI_FETCH_TIMEOUT_EN.
module triangle_fetcher
    import triangle_fetcher_pkg::*;
#(
    parameter  int NUM_TRIANGLE   = 512,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int BIT_TRIANGLE   = $clog2(NUM_TRIANGLE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIT_TRIANGLE:0]   num_tri,
    input  logic                    flush,
    output logic                    busy,
    output logic                    done,
    output logic                    re_IC,
    output logic [BIT_TRIANGLE-1:0] triangle_id,
    input  logic                    rdy_IC,
    input  logic [127:0]            vertex0_IC,
    input  logic [127:0]            vertex1_IC,
    input  logic [127:0]            vertex2_IC,
    input  logic [31:0]             tid_IC,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            out_v0,
    output logic [127:0]            out_v1,
    output logic [127:0]            out_v2,
    output logic [31:0]             out_tid,
    output logic                    out_last
`ifdef TRI_FETCH_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    localparam int IDW  = BIT_TRIANGLE + 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef TRI_FETCH_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    tri_state_e              state_q;
    logic [IDW-1:0]          num_q;
    logic [IDW-1:0]          id_q;
    logic [BIT_TRIANGLE-1:0] tid_q;
    logic                    re_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    discard_q;
    logic [WD_W-1:0]         wd_q;

    logic                    rsp_ok_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    last_s;
    logic                    can_issue_s;
    logic                    drain_done_s;
    logic                    timeout_s;
    logic                    abort_s;
    logic [1:0]              fifo_count_s;
    tri_payload_t            push_pl_s;
    tri_payload_t            head_pl_s;

    // A response counts only for the live request: the re_IC cycle itself or WAIT.
    assign rsp_ok_s     = rdy_IC && ((state_q == ST_REQ && re_q) || state_q == ST_WAIT);
    assign push_s       = rsp_ok_s && !abort_s;
    assign pop_s        = out_valid && out_ready;
    assign last_s       = (id_q == num_q - IDW'(1));
    assign can_issue_s  = (state_q == ST_REQ) && !re_q && !discard_q
                          && (fifo_count_s < 2'(FIFO_DEPTH)) && (id_q < num_q);
    assign drain_done_s = (fifo_count_s == 2'd0) || (fifo_count_s == 2'd1 && pop_s);
    assign timeout_s    = TIMEOUT_EN && (state_q == ST_WAIT) && !rdy_IC
                          && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign abort_s      = flush || timeout_s;

    assign push_pl_s = '{v0: vertex0_IC, v1: vertex1_IC, v2: vertex2_IC, tid: tid_IC, last: last_s};

    tri_fifo2 u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (abort_s),
        .push_i      (push_s),
        .push_data_i (push_pl_s),
        .pop_ready_i (out_ready),
        .valid_o     (out_valid),
        .data_o      (head_pl_s),
        .count_o     (fifo_count_s)
    );

    assign out_v0      = head_pl_s.v0;
    assign out_v1      = head_pl_s.v1;
    assign out_v2      = head_pl_s.v2;
    assign out_tid     = head_pl_s.tid;
    assign out_last    = head_pl_s.last;
    assign busy        = busy_q;
    assign done        = done_q;
    assign re_IC       = re_q;
    assign triangle_id = tid_q;

    // Fetch FSM with its registered request/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            id_q      <= '0;
            tid_q     <= '0;
            re_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            re_q   <= 1'b0;
            done_q <= 1'b0;
            if (discard_q && rdy_IC) begin
                discard_q <= 1'b0;
            end
            if (abort_s) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                id_q    <= '0;
                // The abandoned request's answer may still arrive; swallow it first.
                if (!rdy_IC && ((state_q == ST_REQ && re_q) || state_q == ST_WAIT)) begin
                    discard_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            num_q <= num_tri;
                            id_q  <= '0;
                            if (num_tri == IDW'(0)) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= ST_REQ;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (can_issue_s) begin
                            re_q  <= 1'b1;
                            tid_q <= id_q[BIT_TRIANGLE-1:0];
                        end
                        if (re_q) begin
                            if (rdy_IC) begin
                                id_q <= id_q + IDW'(1);
                                if (last_s) begin
                                    state_q <= ST_DRAIN;
                                end
                            end else begin
                                state_q <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (rdy_IC) begin
                            id_q    <= id_q + IDW'(1);
                            state_q <= last_s ? ST_DRAIN : ST_REQ;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_done_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Counts consecutive unanswered WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (state_q == ST_WAIT && !rdy_IC && !flush) begin
            wd_q <= wd_q + WD_W'(1);
        end else begin
            wd_q <= '0;
        end
    end

`ifdef TRI_FETCH_TIMEOUT_EN
    logic timeout_err_q;

    // Sticky timeout flag, cleared by the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_s) begin
            timeout_err_q <= 1'b1;
        end else if (state_q == ST_IDLE && start && !flush) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_q;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_triangle_fetcher.sv
// Directed bench for triangle_fetcher; timeout steps build only with TRI_FETCH_TIMEOUT_EN.
module tb_triangle_fetcher;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [9:0]   num_tri = 10'd0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic         re_IC;
    logic [8:0]   triangle_id;
    logic         rdy_IC = 1'b0;
    logic [127:0] vertex0_IC = 128'd0;
    logic [127:0] vertex1_IC = 128'd0;
    logic [127:0] vertex2_IC = 128'd0;
    logic [31:0]  tid_IC = 32'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_v0;
    logic [127:0] out_v1;
    logic [127:0] out_v2;
    logic [31:0]  out_tid;
    logic         out_last;
`ifdef TRI_FETCH_TIMEOUT_EN
    logic         timeout_err;
`endif

    int total = 0;
    int bad   = 0;

    triangle_fetcher dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_tri     (num_tri),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .re_IC       (re_IC),
        .triangle_id (triangle_id),
        .rdy_IC      (rdy_IC),
        .vertex0_IC  (vertex0_IC),
        .vertex1_IC  (vertex1_IC),
        .vertex2_IC  (vertex2_IC),
        .tid_IC      (tid_IC),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_v0      (out_v0),
        .out_v1      (out_v1),
        .out_v2      (out_v2),
        .out_tid     (out_tid),
        .out_last    (out_last)
`ifdef TRI_FETCH_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] vtx(input int k, input int id);
        return {32'(k + 1), 32'(id), 32'hC0DE_0000 + 32'(id), 32'h0};
    endfunction

    function automatic logic [31:0] tag(input int id);
        return 32'h7000_0000 + 32'(id);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic wait_re(input int exp_id);
        int n = 0;
        while (re_IC !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("re_seen", re_IC, 128'd1);
        chk("req_id", triangle_id, 128'(exp_id));
    endtask

    task automatic fetch_one(input int id, input int delay);
        wait_re(id);
        for (int d = 0; d < delay; d++) begin
            tick();
            chk("re_one_cycle", re_IC, 128'd0);
        end
        rdy_IC     = 1'b1;
        vertex0_IC = vtx(0, id);
        vertex1_IC = vtx(1, id);
        vertex2_IC = vtx(2, id);
        tid_IC     = tag(id);
        tick();
        rdy_IC     = 1'b0;
    endtask

    task automatic check_out(input int id, input logic last);
        chk("out_valid", out_valid, 128'd1);
        chk("out_tid", out_tid, 128'(tag(id)));
        chk("out_v0", out_v0, vtx(0, id));
        chk("out_v2", out_v2, vtx(2, id));
        chk("out_last", out_last, 128'(last));
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_busy", busy, 128'd0);
        chk("rst_done", done, 128'd0);
        chk("rst_re", re_IC, 128'd0);
        chk("rst_id", triangle_id, 128'd0);
        chk("rst_valid", out_valid, 128'd0);
        chk("rst_v0", out_v0, 128'd0);
        rst = 1'b0;
        tick();

        // three triangles, response two cycles after each request
        out_ready = 1'b1;
        start = 1'b1; num_tri = 10'd3;
        tick();
        start = 1'b0;
        chk("p1_busy", busy, 128'd1);
        fetch_one(0, 2);
        check_out(0, 1'b0);
        chk("p1_no_done", done, 128'd0);
        fetch_one(1, 2);
        check_out(1, 1'b0);
        fetch_one(2, 2);
        check_out(2, 1'b1);
        chk("p1_done_early", done, 128'd0);
        tick();
        chk("p1_done", done, 128'd1);
        chk("p1_idle", busy, 128'd0);
        chk("p1_empty", out_valid, 128'd0);
        tick();
        chk("p1_done_pulse", done, 128'd0);

        // zero-length pass
        start = 1'b1; num_tri = 10'd0;
        tick();
        start = 1'b0;
        chk("p0_done", done, 128'd1);
        chk("p0_busy", busy, 128'd0);
        chk("p0_re", re_IC, 128'd0);
        tick();
        chk("p0_done_pulse", done, 128'd0);
        chk("p0_re2", re_IC, 128'd0);

        // prefetch hits with a stalled consumer: FIFO fills, third request held
        out_ready = 1'b0;
        start = 1'b1; num_tri = 10'd4;
        tick();
        start = 1'b0;
        fetch_one(0, 0);
        fetch_one(1, 0);
        for (int i = 0; i < 4; i++) begin
            chk("full_no_re", re_IC, 128'd0);
            chk("full_hold_tid", out_tid, 128'(tag(0)));
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("full_pop_tid", out_tid, 128'(tag(1)));
        fetch_one(2, 0);
        check_out(2, 1'b0);
        fetch_one(3, 0);
        check_out(3, 1'b1);
        tick();
        chk("p4_done", done, 128'd1);

        // flush while waiting on id 1, then a fresh two-triangle pass
        start = 1'b1; num_tri = 10'd3;
        tick();
        start = 1'b0;
        fetch_one(0, 0);
        check_out(0, 1'b0);
        wait_re(1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_busy", busy, 128'd0);
        chk("fl_valid", out_valid, 128'd0);
        chk("fl_no_done", done, 128'd0);
        start = 1'b1; num_tri = 10'd2;
        tick();
        start = 1'b0;
        chk("fl_restart_busy", busy, 128'd1);
        for (int i = 0; i < 3; i++) begin
            chk("fl_re_held", re_IC, 128'd0);
            tick();
        end
        rdy_IC = 1'b1; tid_IC = 32'hDEAD_BEEF;
        vertex0_IC = 128'd0; vertex1_IC = 128'd0; vertex2_IC = 128'd0;
        tick();
        rdy_IC = 1'b0;
        chk("fl_late_dropped", out_valid, 128'd0);
        fetch_one(0, 1);
        check_out(0, 1'b0);
        fetch_one(1, 1);
        check_out(1, 1'b1);
        tick();
        chk("fl_done", done, 128'd1);

        // reset mid-pass with data pending
        out_ready = 1'b0;
        start = 1'b1; num_tri = 10'd2;
        tick();
        start = 1'b0;
        fetch_one(0, 0);
        chk("mr_valid", out_valid, 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", busy, 128'd0);
        chk("mr_done", done, 128'd0);
        chk("mr_re", re_IC, 128'd0);
        chk("mr_id", triangle_id, 128'd0);
        chk("mr_valid0", out_valid, 128'd0);
        chk("mr_v0", out_v0, 128'd0);
        chk("mr_tid", out_tid, 128'd0);
        chk("mr_last", out_last, 128'd0);
        rdy_IC = 1'b1; tid_IC = 32'h1234_5678;
        tick();
        rdy_IC = 1'b0;
        chk("mr_stray", out_valid, 128'd0);
        chk("mr_stray_re", re_IC, 128'd0);

`ifdef TRI_FETCH_TIMEOUT_EN
        // watchdog: response withheld for sixteen WAIT cycles
        out_ready = 1'b1;
        start = 1'b1; num_tri = 10'd2;
        tick();
        start = 1'b0;
        wait_re(0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("to_not_yet", timeout_err, 128'd0);
        end
        tick();
        chk("to_err", timeout_err, 128'd1);
        chk("to_busy", busy, 128'd0);
        chk("to_no_done", done, 128'd0);
        start = 1'b1; num_tri = 10'd0;
        tick();
        start = 1'b0;
        chk("to_clear", timeout_err, 128'd0);
        chk("to_clear_done", done, 128'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
